// File: rtl/dsp_mac_slice_p.sv
// Parametrised DSP MAC slice: signed pre-adder (D+/-B), multiplier (x A), post-adder with
// selectable Z operand (0 / P feedback / C / PCIN) plus carry-in, optional signed saturation.
// A 1-bit valid token travels alongside the data; every data register loads only when CE is
// high and its own stage holds a valid token, so idle cycles never disturb P.
//
// Ports:
//   i_clk, i_rst_n     clock, synchronous active-low reset (wins over i_ce)
//   i_ce               global clock enable, freezes every register including the valid pipe
//   i_in_valid         operands valid this cycle
//   i_a, i_b, i_d      multiplier operand, pre-adder operands (signed)
//   i_c, i_pcin        post-adder operand (sign-extended), cascade input
//   i_mode             [0] pre-add enable, [1] subtract (D-B), [3:2] Z: 0 / P / C / PCIN
//   i_carryin          post-adder carry-in
//   o_bcout            B after the input stage
//   o_m                multiplier result, aligned with o_p
//   o_p, o_pcout       result and its cascade copy
//   o_carryout, o_ovf  unsigned carry of the post-add, signed overflow of the result
//   o_out_valid        o_p, o_m, o_carryout and o_ovf are valid
module dsp_mac_slice_p #(
  parameter int unsigned AW     = 18,
  parameter int unsigned BW     = 18,
  parameter int unsigned CW     = 48,
  parameter int unsigned PW     = 48,
  parameter int unsigned IREG   = 1,
  parameter int unsigned MREG   = 1,
  parameter int unsigned PREG   = 1,
  parameter int unsigned SAT_EN = 1
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_ce,
  input  logic           i_in_valid,
  input  logic [AW-1:0]  i_a,
  input  logic [BW-1:0]  i_b,
  input  logic [BW-1:0]  i_d,
  input  logic [CW-1:0]  i_c,
  input  logic [PW-1:0]  i_pcin,
  input  logic [3:0]     i_mode,
  input  logic           i_carryin,
  output logic [BW-1:0]  o_bcout,
  output logic [AW+BW:0] o_m,
  output logic [PW-1:0]  o_p,
  output logic [PW-1:0]  o_pcout,
  output logic           o_carryout,
  output logic           o_ovf,
  output logic           o_out_valid
);

  localparam int unsigned MW = AW + BW + 1;

  // ---------------------------------------------------------------- input stage
  logic [AW-1:0] r_a;
  logic [BW-1:0] r_b, r_d;
  logic [CW-1:0] r_c;
  logic [3:0]    r_mode;
  logic          r_cin, r_v1;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_d    <= '0;
      r_c    <= '0;
      r_mode <= '0;
      r_cin  <= 1'b0;
      r_v1   <= 1'b0;
    end else if (i_ce) begin
      r_v1 <= i_in_valid;
      if (i_in_valid) begin
        r_a    <= i_a;
        r_b    <= i_b;
        r_d    <= i_d;
        r_c    <= i_c;
        r_mode <= i_mode;
        r_cin  <= i_carryin;
      end
    end
  end

  logic [AW-1:0] w_a1;
  logic [BW-1:0] w_b1, w_d1;
  logic [CW-1:0] w_c1;
  logic [3:0]    w_mode1;
  logic          w_cin1, w_v1;

  assign w_a1    = (IREG != 0) ? r_a    : i_a;
  assign w_b1    = (IREG != 0) ? r_b    : i_b;
  assign w_d1    = (IREG != 0) ? r_d    : i_d;
  assign w_c1    = (IREG != 0) ? r_c    : i_c;
  assign w_mode1 = (IREG != 0) ? r_mode : i_mode;
  assign w_cin1  = (IREG != 0) ? r_cin  : i_carryin;
  assign w_v1    = (IREG != 0) ? r_v1   : i_in_valid;

  // ------------------------------------------------------ pre-adder / multiplier
  logic signed [BW:0]   w_b_ext, w_d_ext, w_pre;
  logic signed [MW-1:0] w_pre_mw, w_a_mw, w_mult;

  // One extra bit makes D+/-B exact.
  assign w_b_ext = {w_b1[BW-1], w_b1};
  assign w_d_ext = {w_d1[BW-1], w_d1};

  always_comb begin
    w_pre = w_b_ext;
    if (w_mode1[0]) begin
      w_pre = w_mode1[1] ? (w_d_ext - w_b_ext) : (w_d_ext + w_b_ext);
    end
  end

  assign w_pre_mw = MW'(w_pre);
  assign w_a_mw   = MW'($signed(w_a1));
  assign w_mult   = w_pre_mw * w_a_mw;

  // ---------------------------------------------------------- multiplier stage
  logic [MW-1:0] r_m;
  logic [CW-1:0] r_c2;
  logic [1:0]    r_zsel;
  logic          r_cin2, r_v2;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_m    <= '0;
      r_c2   <= '0;
      r_zsel <= '0;
      r_cin2 <= 1'b0;
      r_v2   <= 1'b0;
    end else if (i_ce) begin
      r_v2 <= w_v1;
      if (w_v1) begin
        r_m    <= w_mult;
        r_c2   <= w_c1;
        r_zsel <= w_mode1[3:2];
        r_cin2 <= w_cin1;
      end
    end
  end

  logic [MW-1:0] w_m2;
  logic [CW-1:0] w_c2;
  logic [1:0]    w_zsel2;
  logic          w_cin2, w_v2;

  assign w_m2    = (MREG != 0) ? r_m    : w_mult;
  assign w_c2    = (MREG != 0) ? r_c2   : w_c1;
  assign w_zsel2 = (MREG != 0) ? r_zsel : w_mode1[3:2];
  assign w_cin2  = (MREG != 0) ? r_cin2 : w_cin1;
  assign w_v2    = (MREG != 0) ? r_v2   : w_v1;

  // ---------------------------------------------------------------- post-adder
  logic [PW-1:0] r_p;
  logic [PW-1:0] w_m_ext, w_c_ext, w_z, w_p_next;
  logic [PW:0]   w_sum_s;
  logic          w_ovf, w_co;

  assign w_m_ext = PW'($signed(w_m2));
  assign w_c_ext = PW'($signed(w_c2));

  always_comb begin
    w_z = '0;
    case (w_zsel2)
      2'b00:   w_z = '0;
      2'b01:   w_z = (PREG != 0) ? r_p : '0;
      2'b10:   w_z = w_c_ext;
      default: w_z = i_pcin;
    endcase
  end

  assign w_sum_s = {w_z[PW-1], w_z} + {w_m_ext[PW-1], w_m_ext} + {{PW{1'b0}}, w_cin2};
  assign w_ovf   = w_sum_s[PW] ^ w_sum_s[PW-1];
  // Bit PW of the sign-extended sum is sign(Z)^sign(M)^carry, so the unsigned carry falls out.
  assign w_co    = w_sum_s[PW] ^ w_z[PW-1] ^ w_m_ext[PW-1];

  always_comb begin
    w_p_next = w_sum_s[PW-1:0];
    if ((SAT_EN != 0) && w_ovf) begin
      w_p_next = w_sum_s[PW] ? {1'b1, {(PW-1){1'b0}}} : {1'b0, {(PW-1){1'b1}}};
    end
  end

  // ------------------------------------------------------------------ P stage
  logic [MW-1:0] r_m3;
  logic          r_co, r_ovf, r_v3;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_p   <= '0;
      r_m3  <= '0;
      r_co  <= 1'b0;
      r_ovf <= 1'b0;
      r_v3  <= 1'b0;
    end else if (i_ce) begin
      r_v3 <= w_v2;
      if (w_v2) begin
        r_p   <= w_p_next;
        r_m3  <= w_m2;
        r_co  <= w_co;
        r_ovf <= w_ovf;
      end
    end
  end

  assign o_bcout     = w_b1;
  assign o_m         = (PREG != 0) ? r_m3  : w_m2;
  assign o_p         = (PREG != 0) ? r_p   : w_p_next;
  assign o_pcout     = o_p;
  assign o_carryout  = (PREG != 0) ? r_co  : w_co;
  assign o_ovf       = (PREG != 0) ? r_ovf : w_ovf;
  assign o_out_valid = (PREG != 0) ? r_v3  : w_v2;

endmodule

// File: tb/tb_dsp_mac_slice_p.sv
module tb_dsp_mac_slice_p;

  typedef struct {
    int unsigned inst;
    int          due;
    logic [47:0] p;
    logic [36:0] m;
    logic        co;
    logic        ovf;
  } res_t;

  localparam longint MASK = 64'h0000_FFFF_FFFF_FFFF;
  localparam longint PMAX = 64'sh0000_7FFF_FFFF_FFFF;
  localparam longint PMIN = -PMAX - 64'sd1;

  logic        clk;
  logic        rst_n, ce, in_valid, cin;
  logic [17:0] a, b, d;
  logic [47:0] c, pcin;
  logic [3:0]  mode;

  logic [17:0] dbc [3];
  logic [36:0] dm  [3];
  logic [47:0] dp  [3];
  logic [47:0] dpc [3];
  logic        dco [3];
  logic        dov [3];
  logic        dv  [3];

  int n_chk = 0;
  int n_fail = 0;

  // u0: defaults (L=3, saturating); u1: wrapping; u2: IREG=MREG=0 (L=1).
  dsp_mac_slice_p u0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_ce(ce), .i_in_valid(in_valid), .i_a(a), .i_b(b),
    .i_d(d), .i_c(c), .i_pcin(pcin), .i_mode(mode), .i_carryin(cin), .o_bcout(dbc[0]),
    .o_m(dm[0]), .o_p(dp[0]), .o_pcout(dpc[0]), .o_carryout(dco[0]), .o_ovf(dov[0]),
    .o_out_valid(dv[0])
  );
  dsp_mac_slice_p #(.SAT_EN(0)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_ce(ce), .i_in_valid(in_valid), .i_a(a), .i_b(b),
    .i_d(d), .i_c(c), .i_pcin(pcin), .i_mode(mode), .i_carryin(cin), .o_bcout(dbc[1]),
    .o_m(dm[1]), .o_p(dp[1]), .o_pcout(dpc[1]), .o_carryout(dco[1]), .o_ovf(dov[1]),
    .o_out_valid(dv[1])
  );
  dsp_mac_slice_p #(.IREG(0), .MREG(0)) u2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_ce(ce), .i_in_valid(in_valid), .i_a(a), .i_b(b),
    .i_d(d), .i_c(c), .i_pcin(pcin), .i_mode(mode), .i_carryin(cin), .o_bcout(dbc[2]),
    .o_m(dm[2]), .o_p(dp[2]), .o_pcout(dpc[2]), .o_carryout(dco[2]), .o_ovf(dov[2]),
    .o_out_valid(dv[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // ------------------------------------------------------------ reference model
  res_t        pend [$];
  res_t        held [3];
  logic [47:0] acc  [3];
  bit          mv   [3];
  logic [17:0] bc;
  int          cnt;
  bit          live = 1'b0;

  function automatic int lat(input int k);
    return (k == 2) ? 1 : 3;
  endfunction

  function automatic bit sat(input int k);
    return k != 1;
  endfunction

  // Whole result of one token from plain integer arithmetic. Feedback uses the previous
  // token's result of the same slice, which is what P holds when this token reaches it.
  function automatic res_t calc(input int k);
    res_t   r;
    longint sa, sb, sd, pre, m, z, s, ci, us;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sd = longint'($signed(d));
    if (mode[0]) pre = mode[1] ? sd - sb : sd + sb;
    else         pre = sb;
    m = pre * sa;
    case (mode[3:2])
      2'd0:    z = 0;
      2'd1:    z = longint'($signed(acc[k]));
      2'd2:    z = longint'($signed(c));
      default: z = longint'($signed(pcin));
    endcase
    ci = longint'(cin);
    s  = z + m + ci;
    us = (z & MASK) + (m & MASK) + ci;
    r.inst = k;
    r.due  = 0;
    r.co   = us[48];
    r.ovf  = (s > PMAX) || (s < PMIN);
    if (sat(k) && r.ovf) s = (s > 0) ? PMAX : PMIN;
    r.p = s[47:0];
    r.m = m[36:0];
    return r;
  endfunction

  task automatic model_edge();
    res_t keep [$];
    res_t r;
    res_t zr;
    zr = '{inst: 0, due: 0, p: '0, m: '0, co: 1'b0, ovf: 1'b0};
    if (!rst_n) begin
      pend.delete();
      cnt = 0;
      bc  = '0;
      for (int k = 0; k < 3; k++) begin
        held[k] = zr;
        acc[k]  = '0;
        mv[k]   = 1'b0;
      end
    end else if (ce) begin
      cnt++;
      if (in_valid) begin
        bc = b;
        for (int k = 0; k < 3; k++) begin
          r      = calc(k);
          acc[k] = r.p;
          r.due  = cnt + lat(k) - 1;
          pend.push_back(r);
        end
      end
      for (int k = 0; k < 3; k++) mv[k] = 1'b0;
      foreach (pend[i]) begin
        if (pend[i].due == cnt) begin
          held[pend[i].inst] = pend[i];
          mv[pend[i].inst]   = 1'b1;
        end else begin
          keep.push_back(pend[i]);
        end
      end
      pend = keep;
    end
    live = 1'b1;
  endtask

  initial forever begin
    @(posedge clk);
    model_edge();
  end

  // Compare every output of every slice against the model each cycle.
  initial forever begin
    @(negedge clk);
    if (live) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("u%0d_out_valid", k), 64'(dv[k]), 64'(mv[k]));
        chk($sformatf("u%0d_p", k), 64'(dp[k]), 64'(held[k].p));
        chk($sformatf("u%0d_pcout", k), 64'(dpc[k]), 64'(held[k].p));
        chk($sformatf("u%0d_m", k), 64'(dm[k]), 64'(held[k].m));
        chk($sformatf("u%0d_carryout", k), 64'(dco[k]), 64'(held[k].co));
        chk($sformatf("u%0d_ovf", k), 64'(dov[k]), 64'(held[k].ovf));
        chk($sformatf("u%0d_bcout", k), 64'(dbc[k]), 64'((k < 2) ? bc : b));
      end
    end
  end

  // ------------------------------------------------------------------- stimulus
  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic set_in(input logic v, input logic [17:0] ia, input logic [17:0] ib,
                        input logic [17:0] id, input logic [47:0] ic, input logic [3:0] im,
                        input logic icin);
    in_valid = v;
    a = ia;
    b = ib;
    d = id;
    c = ic;
    mode = im;
    cin = icin;
  endtask

  task automatic randomize_inputs();
    in_valid = ($urandom_range(0, 9) < 6);
    a    = 18'($urandom);
    b    = 18'($urandom);
    d    = 18'($urandom);
    mode = 4'($urandom);
    cin  = 1'($urandom);
    case ($urandom_range(0, 3))
      0:       c = 48'h7FFF_FFFF_FFFF - 48'($urandom_range(0, 1000));
      1:       c = 48'h8000_0000_0000 + 48'($urandom_range(0, 1000));
      default: c = {16'($urandom), 32'($urandom)};
    endcase
  endtask

  logic [47:0] ph0 [11];
  logic [47:0] ph2 [11];
  logic        vh0 [11];
  logic        vh2 [11];

  initial begin
    rst_n = 1'b0;
    ce    = 1'b0;
    pcin  = '0;
    set_in(1'b0, '0, '0, '0, '0, 4'b0000, 1'b0);

    // Reset with random activity on every input.
    for (int i = 0; i < 10; i++) begin
      randomize_inputs();
      ce = 1'($urandom);
      tick();
    end
    rst_n = 1'b1;
    ce    = 1'b1;
    set_in(1'b0, '0, '0, '0, '0, 4'b0000, 1'b0);
    tick();
    tick();

    // Pre-subtract: (25-10)*20 = 300.
    set_in(1'b1, 18'd20, 18'd10, 18'd25, 48'd0, 4'b0011, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("presub_p", 64'(dp[0]), 64'h12C);
    chk("presub_pcout", 64'(dpc[0]), 64'h12C);
    chk("presub_m", 64'(dm[0]), 64'h12C);
    chk("presub_bcout", 64'(dbc[0]), 64'hA);
    chk("presub_carryout", 64'(dco[0]), 64'h0);
    chk("presub_ovf", 64'(dov[0]), 64'h0);
    chk("presub_valid", 64'(dv[0]), 64'h1);
    tick();
    chk("presub_valid_drop", 64'(dv[0]), 64'h0);

    // Accumulate (D+B)*A = 30 onto P, four back-to-back, three idle, one more.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      set_in((i <= 4) || (i == 8), 18'd5, 18'd6, 18'd0, 48'd0, 4'b0101, 1'b0);
      tick();
      ph0[i] = dp[0];
      vh0[i] = dv[0];
      ph2[i] = dp[2];
      vh2[i] = dv[2];
    end
    in_valid = 1'b0;
    chk("acc_p3", 64'(ph0[3]), 64'd30);
    chk("acc_p4", 64'(ph0[4]), 64'd60);
    chk("acc_p5", 64'(ph0[5]), 64'd90);
    chk("acc_p6", 64'(ph0[6]), 64'd120);
    chk("acc_hold_p", 64'(ph0[9]), 64'd120);
    chk("acc_hold_valid", 64'(vh0[9]), 64'd0);
    chk("acc_p10", 64'(ph0[10]), 64'd150);
    chk("acc_valid10", 64'(vh0[10]), 64'd1);
    chk("acc_l1_p4", 64'(ph2[4]), 64'd120);
    chk("acc_l1_p8", 64'(ph2[8]), 64'd150);
    chk("acc_l1_valid8", 64'(vh2[8]), 64'd1);

    // Negative product onto cascade input: 3000 + (0-6)*5 = 2970.
    pcin = 48'd3000;
    tick();
    set_in(1'b1, 18'd5, 18'd6, 18'd0, 48'd0, 4'b1111, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("casc_m", 64'(dm[0]), 64'h1F_FFFF_FFE2);
    chk("casc_p", 64'(dp[0]), 64'hB9A);
    chk("casc_carryout", 64'(dco[0]), 64'h1);
    chk("casc_ovf", 64'(dov[0]), 64'h0);

    // Positive overflow: C = max, product = 1.
    set_in(1'b1, 18'd1, 18'd1, 18'd0, 48'h7FFF_FFFF_FFFF, 4'b1001, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("sat_p", 64'(dp[0]), 64'h7FFF_FFFF_FFFF);
    chk("sat_ovf", 64'(dov[0]), 64'h1);
    chk("sat_carryout", 64'(dco[0]), 64'h0);
    chk("wrap_p", 64'(dp[1]), 64'h8000_0000_0000);
    chk("wrap_ovf", 64'(dov[1]), 64'h1);

    // CE stall with two tokens in flight; junk offered during the stall is not taken.
    for (int i = 1; i <= 8; i++) begin
      ce = !((i >= 3) && (i <= 6));
      if (i == 1)      set_in(1'b1, 18'd2, 18'd3, 18'd0, 48'd100, 4'b1000, 1'b0);
      else if (i == 2) set_in(1'b1, 18'd4, 18'd5, 18'd0, 48'd200, 4'b1000, 1'b0);
      else if (i <= 6) set_in(1'b1, 18'd7, 18'd7, 18'd0, 48'd7, 4'b1000, 1'b0);
      else             set_in(1'b0, 18'd0, 18'd0, 18'd0, 48'd0, 4'b1000, 1'b0);
      tick();
      ph0[i] = dp[0];
      vh0[i] = dv[0];
      ph2[i] = dp[2];
      vh2[i] = dv[2];
    end
    ce = 1'b1;
    chk("stall_valid_frozen", 64'(vh0[6]), 64'd0);
    chk("stall_tok1_p", 64'(ph0[7]), 64'd106);
    chk("stall_tok1_valid", 64'(vh0[7]), 64'd1);
    chk("stall_tok2_p", 64'(ph0[8]), 64'd220);
    chk("stall_tok2_valid", 64'(vh0[8]), 64'd1);
    chk("stall_l1_hold_valid", 64'(vh2[6]), 64'd1);
    chk("stall_l1_hold_p", 64'(ph2[6]), 64'd220);
    chk("stall_l1_valid_drop", 64'(vh2[7]), 64'd0);

    // Random traffic with CE gaps and occasional resets; cascade input held constant.
    pcin = {16'($urandom), 32'($urandom)};
    tick();
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 99) >= 2);
      ce    = ($urandom_range(0, 9) < 8);
      randomize_inputs();
      tick();
    end
    rst_n = 1'b1;
    ce    = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
